// File: rtl/msi_pkg.sv
// Shared encodings for the MSI cache controller and its datapath.
package msi_pkg;
  typedef enum logic [1:0] {
    P_READ  = 2'b00,
    P_WRITE = 2'b01,
    B_READ  = 2'b10,
    B_WRITE = 2'b11
  } func_t;

  // 01 is not a legal line status
  typedef enum logic [1:0] {
    INVL = 2'b00,
    SHRD = 2'b10,
    EXCL = 2'b11
  } stat_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITE, WB, SNOOP, FILL, DONE
  } state_t;
endpackage

// File: rtl/msi_cache_ctrl_bus_timer.sv
// Bus-transfer watchdog: counts granted cycles without mem_ack.
module bus_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (en)        cnt <= cnt + 1'b1;
  end

  // High when the next enabled count reaches TIMEOUT
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/msi_cache_ctrl.sv
// Per-cache MSI control FSM: lookup, write, write-back and fill sequencing.
module msi_cache_ctrl
  import msi_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_req,
  input  logic       p_rw,
  input  logic       read_hit,
  input  logic [1:0] stat,
  input  logic       bus_grant,
  input  logic       mem_ack,
  output logic [1:0] func,
  output logic       snoop_out,
  output logic       bus_req,
  output logic       p_ready,
  output logic       busy,
  output logic       err
);
  state_t state, nxt;
  logic   rw_q, refilled, on_bus, xfer_done, tmr_en, tmr_exp, timeout, err_nxt;

  assign on_bus    = (state == WB) || (state == FILL);
  assign xfer_done = on_bus && bus_grant && mem_ack;
  assign tmr_en    = on_bus && bus_grant && !mem_ack;
  assign timeout   = tmr_en && tmr_exp;

  bus_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!on_bus),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_comb begin
    nxt     = state;
    err_nxt = timeout;
    case (state)
      IDLE:   if (p_req) nxt = LOOKUP;
      LOOKUP: begin
        if (read_hit)              nxt = rw_q ? WRITE : DONE;
        else if (refilled)         begin nxt = IDLE; err_nxt = 1'b1; end
        else if (stat == 2'(EXCL)) nxt = WB;
        else                       nxt = SNOOP;
      end
      WRITE:  nxt = DONE;
      WB:     if (xfer_done) nxt = SNOOP; else if (timeout) nxt = IDLE;
      SNOOP:  nxt = FILL;
      FILL:   if (xfer_done) nxt = LOOKUP; else if (timeout) nxt = IDLE;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      refilled  <= 1'b0;
      func      <= P_READ;
      snoop_out <= 1'b0;
      bus_req   <= 1'b0;
      p_ready   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= nxt;
      if (state == IDLE && p_req) begin
        rw_q     <= p_rw;
        refilled <= 1'b0;
      end
      if (state == FILL && xfer_done) refilled <= 1'b1;
      snoop_out <= (nxt == SNOOP);
      bus_req   <= (nxt == WB) || (nxt == FILL);
      p_ready   <= (nxt == DONE);
      busy      <= (nxt != IDLE);
      err       <= err_nxt;
      if (nxt == WRITE)                  func <= P_WRITE;
      else if (nxt == WB && bus_grant)   func <= B_WRITE;
      else if (nxt == FILL && bus_grant) func <= B_READ;
      else                               func <= P_READ;
    end
  end
endmodule
